// File: rtl/llr_combine_unit_pkg.sv
// llr_pkg: shared types and helpers for the multi-read LLR combiner.
// Holds the FSM state encoding and the saturating add used by every lane.
// The add works on a wide signed container so one function serves any ACC_W.
package llr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2,
    OUTPUT = 2'd3
  } llr_state_t;

  // Container width for the saturating add; ACC_W must stay below this.
  localparam int SUM_W = 64;

  typedef struct packed {
    logic signed [SUM_W-1:0] sum;
    logic                    clipped;
  } sat_res_t;

  // Symmetric saturation limits: +(2^(w-1)-1) and its negation, so the
  // most negative two's-complement code is never produced and |acc| fits.
  function automatic logic signed [SUM_W-1:0] sat_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SUM_W-1:0] sat_min(input int acc_w);
    return -sat_max(acc_w);
  endfunction

  // Both operands arrive sign-extended to SUM_W, so the raw add cannot wrap.
  function automatic sat_res_t sat_add(input logic signed [SUM_W-1:0] acc,
                                       input logic signed [SUM_W-1:0] llr,
                                       input int                      acc_w);
    sat_res_t                r;
    logic signed [SUM_W-1:0] s;
    s         = acc + llr;
    r.sum     = s;
    r.clipped = 1'b0;
    if (s > sat_max(acc_w)) begin
      r.sum     = sat_max(acc_w);
      r.clipped = 1'b1;
    end else if (s < sat_min(acc_w)) begin
      r.sum     = sat_min(acc_w);
      r.clipped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/llr_combine_unit_sat_lane.sv
// llr_sat_lane: one lane accumulator with saturating add and synchronous clear.
// Latency: sum visible one cycle after en; mag/pos/clip are combinational.
// Backpressure: none, the parent qualifies en with its handshake.
// Ports: clk, rst_n, clr (zero the sum), en (add llr), llr (signed lane input),
//        mag (|sum|), pos (sum > 0), clip (this cycle's add saturated).
module llr_sat_lane
  import llr_pkg::*;
#(
  parameter int LLR_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [LLR_W-1:0] llr,
  output logic [ACC_W-1:0] mag,
  output logic             pos,
  output logic             clip
);

  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_nxt;
  logic [SUM_W-1:0]       acc_ext;
  logic [SUM_W-1:0]       llr_ext;
  sat_res_t               res;
  logic [SUM_W-ACC_W-1:0] unused_hi;

  assign acc_ext = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign llr_ext = {{(SUM_W-LLR_W){llr[LLR_W-1]}}, llr};
  assign res     = sat_add(acc_ext, llr_ext, ACC_W);

  // The saturated result always fits ACC_W; the upper bits are sign copies.
  assign acc_nxt   = res.sum[ACC_W-1:0];
  assign unused_hi = res.sum[SUM_W-1:ACC_W];

  assign clip = en & res.clipped;

  // Negation is safe: the most negative code can never be stored.
  assign mag = acc[ACC_W-1] ? (~acc + ACC_W'(1)) : acc;
  assign pos = ~acc[ACC_W-1] & (|acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/llr_combine_unit.sv
// llr_combine_unit: accumulates per-read signed LLR vectors of a cluster with
// saturation and issues hard bits, per-lane |sum|, read count and sticky sat.
// Latency: out_valid rises two cycles after the final accepted beat.
// Backpressure: in_ready only in ACCUM; decision held until out_ready.
// Ports: clk/rst_n (async active-low); start+num_reads open a cluster in IDLE;
//        in_valid/in_ready/in_llr/in_last carry read vectors (lane i at
//        [i*LLR_W +: LLR_W]); out_valid/out_ready/out_bits/out_conf/out_nreads/
//        out_sat carry the decision; busy is high whenever not IDLE.
// Build option: define LLR_COMBINE_ERASURE_EN to add out_erase, which flags
//        lanes with |sum| < ERASE_THR and forces their hard bit to 0.
module llr_combine_unit
  import llr_pkg::*;
#(
  parameter  int N_POS     = 10,
  parameter  int LLR_W     = 16,
  parameter  int ACC_W     = 24,
  parameter  int MAX_READS = 16,
  parameter  int ERASE_THR = 4,
  localparam int CNT_W     = $clog2(MAX_READS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_reads,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_POS*LLR_W-1:0] in_llr,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_POS-1:0]       out_bits,
  output logic [N_POS*ACC_W-1:0] out_conf,
  output logic [CNT_W-1:0]       out_nreads,
  output logic                   out_sat,
`ifdef LLR_COMBINE_ERASURE_EN
  output logic [N_POS-1:0]       out_erase,
`endif
  output logic                   busy
);

  llr_state_t             state;
  logic [CNT_W-1:0]       nreq;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       nreq_clamped;
  logic                   sat_flg;
  logic                   accept;
  logic                   clr_acc;
  logic [N_POS-1:0]       lane_pos;
  logic [N_POS-1:0]       lane_clip;
  logic [N_POS*ACC_W-1:0] lane_mag;
  logic [N_POS-1:0]       bits_nxt;

  // in_ready is registered high only while in ACCUM, so it alone gates accept.
  assign accept       = in_valid & in_ready;
  assign clr_acc      = (state == IDLE) & start;
  assign cnt_inc      = count + CNT_W'(1);
  assign nreq_clamped = (num_reads > CNT_W'(MAX_READS)) ? CNT_W'(MAX_READS)
                                                        : num_reads;

  for (genvar i = 0; i < N_POS; i++) begin : g_lane
    llr_sat_lane #(
      .LLR_W(LLR_W),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr_acc),
      .en   (accept),
      .llr  (in_llr[i*LLR_W +: LLR_W]),
      .mag  (lane_mag[i*ACC_W +: ACC_W]),
      .pos  (lane_pos[i]),
      .clip (lane_clip[i])
    );
  end

`ifdef LLR_COMBINE_ERASURE_EN
  logic [N_POS-1:0] lane_erase;

  for (genvar i = 0; i < N_POS; i++) begin : g_erase
    assign lane_erase[i] = lane_mag[i*ACC_W +: ACC_W] < ACC_W'(ERASE_THR);
  end

  // Low-confidence lanes are reported as erased and never decide 1.
  assign bits_nxt = lane_pos & ~lane_erase;
`else
  localparam int unused_erase_thr = ERASE_THR;

  assign bits_nxt = lane_pos;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      nreq       <= '0;
      count      <= '0;
      sat_flg    <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_bits   <= '0;
      out_conf   <= '0;
      out_nreads <= '0;
      out_sat    <= 1'b0;
`ifdef LLR_COMBINE_ERASURE_EN
      out_erase  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nreq    <= nreq_clamped;
            count   <= '0;
            sat_flg <= 1'b0;
            busy    <= 1'b1;
            if (num_reads == '0) begin
              state <= DECIDE;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            count <= cnt_inc;
            if (|lane_clip) sat_flg <= 1'b1;
            // in_last on the final expected beat is one exit, not two.
            if (in_last || (cnt_inc == nreq)) begin
              state    <= DECIDE;
              in_ready <= 1'b0;
            end
          end
        end
        DECIDE: begin
          out_bits   <= bits_nxt;
          out_conf   <= lane_mag;
          out_nreads <= count;
          out_sat    <= sat_flg;
`ifdef LLR_COMBINE_ERASURE_EN
          out_erase  <= lane_erase;
`endif
          out_valid  <= 1'b1;
          state      <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llr_combine_unit.sv
module tb_llr_combine_unit;

  localparam int N_POS     = 4;
  localparam int LLR_W     = 7;
  localparam int ACC_W     = 8;
  localparam int MAX_READS = 16;
  localparam int CNT_W     = 5;
  localparam int SAT_LIM   = 127;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [CNT_W-1:0]       num_reads = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [N_POS*LLR_W-1:0] in_llr = '0;
  logic                   in_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [N_POS-1:0]       out_bits;
  logic [N_POS*ACC_W-1:0] out_conf;
  logic [CNT_W-1:0]       out_nreads;
  logic                   out_sat;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  logic [LLR_W-1:0] vec [0:MAX_READS-1][0:N_POS-1];

  llr_combine_unit #(
    .N_POS(N_POS), .LLR_W(LLR_W), .ACC_W(ACC_W), .MAX_READS(MAX_READS), .ERASE_THR(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_reads(num_reads),
    .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_conf(out_conf), .out_nreads(out_nreads), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int b, input int a0, input int a1, input int a2, input int a3);
    vec[b][0] = LLR_W'(a0);
    vec[b][1] = LLR_W'(a1);
    vec[b][2] = LLR_W'(a2);
    vec[b][3] = LLR_W'(a3);
  endtask

  task automatic rand_vecs();
    for (int b = 0; b < MAX_READS; b++)
      for (int l = 0; l < N_POS; l++) vec[b][l] = LLR_W'($urandom);
  endtask

  task automatic drive_vec(input int b);
    for (int l = 0; l < N_POS; l++) in_llr[l*LLR_W +: LLR_W] = vec[b][l];
  endtask

  // Reference: per-lane integer sums clamped to +/-SAT_LIM after every read.
  task automatic model(input int nbeats, output logic [N_POS-1:0] eb,
                       output logic [N_POS*ACC_W-1:0] ec, output logic es);
    int s;
    es = 1'b0;
    eb = '0;
    ec = '0;
    for (int l = 0; l < N_POS; l++) begin
      s = 0;
      for (int b = 0; b < nbeats; b++) begin
        s = s + int'($signed(vec[b][l]));
        if (s > SAT_LIM) begin s = SAT_LIM; es = 1'b1; end
        if (s < -SAT_LIM) begin s = -SAT_LIM; es = 1'b1; end
      end
      eb[l] = (s > 0);
      ec[l*ACC_W +: ACC_W] = ACC_W'(s < 0 ? -s : s);
    end
  endtask

  task automatic run_cluster(input int nreq, input int last_at, input bit gaps, input int hold);
    int ncl, exp_cnt, acc;
    bit v;
    logic [N_POS-1:0] eb;
    logic [N_POS*ACC_W-1:0] ec;
    logic es;
    ncl     = (nreq > MAX_READS) ? MAX_READS : nreq;
    exp_cnt = (last_at >= 0 && last_at + 1 < ncl) ? last_at + 1 : ncl;
    model(exp_cnt, eb, ec, es);
    start     = 1'b1;
    num_reads = CNT_W'(nreq);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    acc = 0;
    while (acc < exp_cnt) begin
      v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      in_last  = (acc == last_at);
      drive_vec(acc);
      check("in_ready_accum", in_ready, 1);
      tick();
      if (v) acc++;
    end
    // Stray beat offered in DECIDE: must not be taken.
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_llr   = (N_POS*LLR_W)'($urandom);
    check("in_ready_decide", in_ready, 0);
    check("out_valid_early", out_valid, 0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("out_valid", out_valid, 1);
    check("out_bits", out_bits, eb);
    check("out_conf", out_conf, ec);
    check("out_nreads", out_nreads, exp_cnt);
    check("out_sat", out_sat, es);
    for (int h = 0; h < hold; h++) begin
      start     = 1'b1;
      num_reads = CNT_W'(3);
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_conf", out_conf, ec);
      check("hold_bits", out_bits, eb);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);
    check("kept_nreads", out_nreads, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bits", out_bits, 0);
    check("rst_out_conf", out_conf, 0);
    check("rst_out_nreads", out_nreads, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Three identical reads {+5,-5,+1,0}.
    for (int b = 0; b < 3; b++) set_vec(b, 5, -5, 1, 0);
    run_cluster(3, -1, 1'b0, 0);
    check("t1_bits_const", out_bits, 4'b0101);
    check("t1_conf_const", out_conf, {8'd0, 8'd3, 8'd15, 8'd15});

    // Early termination on read 2 of 8, decision held 5 cycles with start pulses.
    set_vec(0, 10, 10, 10, 10);
    set_vec(1, -4, -4, -4, -4);
    set_vec(2, 20, 20, 20, 20);
    run_cluster(8, 1, 1'b0, 5);
    check("t2_conf_const", out_conf, {8'd6, 8'd6, 8'd6, 8'd6});

    // Saturation then a small cluster clears the sticky flag.
    for (int b = 0; b < 4; b++) set_vec(b, 60, 1, -60, 0);
    run_cluster(4, -1, 1'b0, 0);
    check("t3_sat_const", out_sat, 1);
    for (int b = 0; b < 2; b++) set_vec(b, 1, 2, 3, -1);
    run_cluster(2, -1, 1'b0, 0);
    check("t3_nosat_const", out_sat, 0);

    // Empty cluster and clamped read count.
    run_cluster(0, -1, 1'b0, 1);
    rand_vecs();
    run_cluster(20, -1, 1'b1, 0);
    // in_last on the final expected beat.
    rand_vecs();
    run_cluster(5, 4, 1'b1, 0);

    // Reset mid-cluster discards everything.
    rand_vecs();
    start     = 1'b1;
    num_reads = CNT_W'(4);
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      drive_vec(b);
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_bits", out_bits, 0);
    check("mid_rst_conf", out_conf, 0);
    check("mid_rst_nreads", out_nreads, 0);
    tick();
    rst_n = 1'b1;
    tick();
    rand_vecs();
    run_cluster(4, -1, 1'b0, 0);

    // Randomized clusters.
    for (int k = 0; k < 20; k++) begin
      int nreq, last_at;
      rand_vecs();
      nreq    = $urandom_range(0, 18);
      last_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 17) : -1;
      run_cluster(nreq, last_at, 1'b1, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/llr_combine_unit.md
Name: llr_combine_unit

Overview:
Multi-read likelihood combiner for the DNA strand decoding path. It takes per-position signed LLR vectors from a soft or hard decoder core, one vector per read of a cluster, using a valid/ready handshake. It accumulates them with saturation. At the end of the cluster it issues hard bits plus a per-position confidence vector through an output valid/ready handshake.

Parameters:
N_POS, 10, strand positions (lanes) per vector
LLR_W, 16, signed width of each incoming lane LLR
ACC_W, 24, signed accumulator width per lane; must be >= LLR_W+1
MAX_READS, 16, maximum reads per cluster; read counter width CNT_W = $clog2(MAX_READS+1)
ERASE_THR, 4, erasure threshold on |sum| (used only with ERASURE_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin a new cluster; sampled only in IDLE
num_reads  in  CNT_W  expected read count, latched on start
in_valid  in  1  input LLR vector valid
in_ready  out  1  unit accepts a vector
in_llr  in  N_POS*LLR_W  packed signed LLRs; lane i = bits [i*LLR_W +: LLR_W]
in_last  in  1  final read of cluster (early termination)
out_valid  out  1  decision available
out_ready  in  1  consumer accepts decision
out_bits  out  N_POS  hard decisions
out_conf  out  N_POS*ACC_W  per-lane |sum|, packed like in_llr
out_nreads  out  CNT_W  reads actually accumulated
out_sat  out  1  at least one lane saturated during this cluster
busy  out  1  state != IDLE

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_bits=0, out_conf=0, out_nreads=0, out_sat=0, busy=0. Accumulators, count and sticky sat flag are 0. State is IDLE.
- FSM states: IDLE, ACCUM, DECIDE, OUTPUT.
- IDLE:
  - start=1 latches num_reads (clamped to MAX_READS), clears all accumulators, count and sat.
  - Next state is ACCUM, or DECIDE if num_reads==0.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - On acceptance: acc[i] <= sat(acc[i] + sext(in_llr[i])) and count++.
  - Saturation limits are +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)-1); the most negative code is never produced. Any clamp sets the sticky sat flag.
  - Go to DECIDE on an accepted beat with in_last=1, or when count+1 == latched num_reads.
- DECIDE (one cycle, in_ready=0):
  - out_bits[i] = (acc[i] > 0); a zero sum decides 0.
  - out_conf[i] = |acc[i]|; out_nreads = count; out_sat = sat flag.
  - All outputs are registered. Next state is OUTPUT.
- OUTPUT:
  - out_valid=1 and outputs are held stable until out_ready=1.
  - On handshake: out_valid drops the next cycle and state returns to IDLE.
  - Outputs keep their values until the next DECIDE.
- Latency: out_valid rises 2 cycles after the last beat is accepted: accept edge, then DECIDE edge.
- Throughput: one vector per cycle in ACCUM. Minimum cluster turnaround is N+3 cycles with out_ready tied high.
- Boundary rules:
  - start outside IDLE is ignored.
  - in_valid outside ACCUM is not accepted and is not consumed.
  - in_last on the num_reads-th beat gives a single transition, no double count.
  - Empty cluster (num_reads=0): bits=0, conf=0, nreads=0.
  - rst_n asserted mid-operation: immediate return to reset values; any partial cluster is discarded.

Optional Feature:
- Macro: LLR_COMBINE_ERASURE_EN.
- Defined:
  - Adds output port out_erase [N_POS], registered in DECIDE.
  - out_erase[i] = (|acc[i]| < ERASE_THR); erased lanes force out_bits[i]=0.
  - out_erase resets to 0.
- Undefined: no port and no comparators; decisions follow the rule above.

Decomposition:
- Package llr_pkg:
  - state enum llr_state_t (IDLE, ACCUM, DECIDE, OUTPUT);
  - localparams for the saturation limits;
  - function sat_add(acc, llr) returning {sum, clipped}.
- Sub-module llr_sat_lane: one lane's accumulator register, saturating add, clear and clip output. It is generated N_POS times; the top holds the FSM, counter and output registers.

Test Plan:
- N_POS=4, num_reads=3, lanes {+5,-5,+1,0} each read → out_bits=4'b0101 (lane0=1), out_conf lanes {15,15,3,0}, nreads=3, out_valid 2 cycles after third accept.
- num_reads=8, in_last on read 2, vectors {+10,...},{-4,...} → nreads=2, lane0 conf=6, bit=1; the third in_valid stays unaccepted (in_ready=0).
- ACC_W=8, 4 reads of +100 on lane0 → conf=127, out_sat=1. A following cluster with small values gives out_sat=0.
- out_ready held low 5 cycles → outputs stable, start pulses ignored. After out_ready the next start is accepted in IDLE.
- rst_n pulsed after 2 of 4 reads → all outputs 0, state IDLE. A new cluster yields sums only from post-reset reads.
- ERASURE_EN, ERASE_THR=4, lane sums {+3,-4,+4,0} → out_erase=4'b1001, out_bits=4'b0100.
